// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default data width, hardwired-zero register index,
// and the state encoding for the register-file clear sequencer.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/cpu_regfile_clear_seq.sv
// Clear sequencer for cpu_regfile_mp: walks registers 1..NREGS-1 once per
// clr_req, driving a clear-write strobe/address and the busy/done handshake.
module cpu_regfile_clear_seq
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt;
  logic          done_q;
  logic          last;

  assign last = (cnt == AW'(NREGS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (last)    state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // done is registered so it lands in the first IDLE cycle after the final clear write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && clr_req) cnt <= AW'(1);
      else if (state == ST_CLEAR)      cnt <= cnt + AW'(1);
      done_q <= (state == ST_CLEAR) && last;
    end
  end

  always_comb begin
    clr_busy = (state == ST_CLEAR);
    clr_we   = (state == ST_CLEAR);
    clr_addr = cnt;
    clr_done = done_q;
  end

endmodule

// File: rtl/cpu_regfile_mp.sv
// Parametrised multi-port integer register file with x0 hardwired to zero and
// an on-demand clear pass. Optional write-to-read bypass: `define REGFILE_BYPASS_EN.
module cpu_regfile_mp
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;

  cpu_regfile_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Ascending port order: the highest-numbered port wins on an address collision.
  // Port writes only happen outside a clear pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (we[j] && wa[j*AW +: AW] != ZERO_ADDR)
          regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = ra[i*AW +: AW];

    always_comb begin
      val = (addr == ZERO_ADDR) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
      if (!clr_busy && addr != ZERO_ADDR) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (we[j] && wa[j*AW +: AW] == addr) val = wd[j*XLEN +: XLEN];
        end
      end
`endif
    end

    assign rd[i*XLEN +: XLEN] = val;
  end

endmodule
